// File: rtl/burst_memtest_engine_if.sv
// Avalon burst write/read master pair as seen from the user-logic side.
// The engine uses the master modport and the master pair/memory uses the slave modport.
interface burst_memtest_engine_if #(
    parameter int ADDRESSWIDTH = 28,
    parameter int DATAWIDTH    = 32
);
    logic                    write_control_done;
    logic                    write_control_fixed_location;
    logic [ADDRESSWIDTH-1:0] write_control_write_base;
    logic [ADDRESSWIDTH-1:0] write_control_write_length;
    logic                    write_control_go;
    logic                    write_user_write_buffer;
    logic [DATAWIDTH-1:0]    write_user_buffer_data;
    logic                    write_user_buffer_full;

    logic                    read_control_done;
    logic                    read_control_fixed_location;
    logic [ADDRESSWIDTH-1:0] read_control_read_base;
    logic [ADDRESSWIDTH-1:0] read_control_read_length;
    logic                    read_control_go;
    logic                    read_user_read_buffer;
    logic [DATAWIDTH-1:0]    read_user_buffer_output_data;
    logic                    read_user_data_available;

    modport master (
        input  write_control_done,
        output write_control_fixed_location,
        output write_control_write_base,
        output write_control_write_length,
        output write_control_go,
        output write_user_write_buffer,
        output write_user_buffer_data,
        input  write_user_buffer_full,
        input  read_control_done,
        output read_control_fixed_location,
        output read_control_read_base,
        output read_control_read_length,
        output read_control_go,
        output read_user_read_buffer,
        input  read_user_buffer_output_data,
        input  read_user_data_available
    );

    modport slave (
        output write_control_done,
        input  write_control_fixed_location,
        input  write_control_write_base,
        input  write_control_write_length,
        input  write_control_go,
        input  write_user_write_buffer,
        input  write_user_buffer_data,
        output write_user_buffer_full,
        output read_control_done,
        input  read_control_fixed_location,
        input  read_control_read_base,
        input  read_control_read_length,
        input  read_control_go,
        input  read_user_read_buffer,
        output read_user_buffer_output_data,
        output read_user_data_available
    );
endinterface

// File: rtl/burst_memtest_engine.sv
// Burst memory tester: writes a counting pattern through the write master,
// reads it back through the read master and reports mismatches.
module burst_memtest_engine #(
    parameter int ADDRESSWIDTH    = 28,
    parameter int DATAWIDTH       = 32,
    parameter int BYTEENABLEWIDTH = 4,
    parameter int MAX_WORDS       = 256,
    localparam int COUNTW         = $clog2(MAX_WORDS + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [1:0]              mode,
    input  logic [ADDRESSWIDTH-1:0] base_address,
    input  logic [COUNTW-1:0]       num_words,
    input  logic [DATAWIDTH-1:0]    seed,
    output logic                    busy,
    output logic                    done,
    output logic [COUNTW-1:0]       error_count,
    output logic [ADDRESSWIDTH-1:0] first_error_addr,
    output logic [DATAWIDTH-1:0]    last_read_data,
    burst_memtest_engine_if.master  avm
);
    typedef enum logic [2:0] {
        IDLE, WR_GO, WR_STREAM, WR_WAIT, RD_GO, RD_STREAM, RD_WAIT, FINISH
    } state_t;

    state_t state_reg, state_next;

    logic [1:0]              mode_reg;
    logic [ADDRESSWIDTH-1:0] base_reg;
    logic [COUNTW-1:0]       len_reg;
    logic [DATAWIDTH-1:0]    seed_reg;
    logic [COUNTW-1:0]       wr_cnt_reg;
    logic [COUNTW-1:0]       rd_cnt_reg;
    logic [COUNTW-1:0]       error_count_reg;
    logic [ADDRESSWIDTH-1:0] first_error_addr_reg;
    logic [DATAWIDTH-1:0]    last_read_data_reg;
    logic                    busy_reg;
    logic                    done_reg;

    logic                    accept;
    logic                    wr_go;
    logic                    rd_go;
    logic                    push;
    logic                    pop;
    logic                    mismatch;
    logic [COUNTW-1:0]       len_in;
    logic [COUNTW-1:0]       wr_cnt_inc;
    logic [COUNTW-1:0]       rd_cnt_inc;
    logic [DATAWIDTH-1:0]    rd_expected;
    logic [ADDRESSWIDTH-1:0] rd_addr;
    logic [ADDRESSWIDTH-1:0] byte_length;

    assign accept      = (state_reg == IDLE) && start;
    assign len_in      = (num_words > COUNTW'(MAX_WORDS)) ? COUNTW'(MAX_WORDS) : num_words;
    assign wr_cnt_inc  = wr_cnt_reg + COUNTW'(1);
    assign rd_cnt_inc  = rd_cnt_reg + COUNTW'(1);
    assign rd_expected = seed_reg + DATAWIDTH'(rd_cnt_reg);
    assign rd_addr     = base_reg + ADDRESSWIDTH'(rd_cnt_reg) * ADDRESSWIDTH'(BYTEENABLEWIDTH);
    assign byte_length = ADDRESSWIDTH'(len_reg) * ADDRESSWIDTH'(BYTEENABLEWIDTH);
    assign mismatch    = avm.read_user_buffer_output_data != rd_expected;

    always_ff @(posedge clk) begin
        if (!reset) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        wr_go      = 1'b0;
        rd_go      = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (len_in == '0)       state_next = FINISH;
                    else if (mode == 2'd1)  state_next = RD_GO;
                    else                    state_next = WR_GO;
                end
            end
            WR_GO: begin
                wr_go      = 1'b1;
                state_next = WR_STREAM;
            end
            WR_STREAM: begin
                push = !avm.write_user_buffer_full && (wr_cnt_reg < len_reg);
                // Leave as soon as the last word is accepted so no idle cycle is spent here.
                if ((wr_cnt_reg == len_reg) || (push && wr_cnt_inc == len_reg))
                    state_next = WR_WAIT;
            end
            WR_WAIT: begin
                if (avm.write_control_done)
                    state_next = (mode_reg == 2'd0) ? FINISH : RD_GO;
            end
            RD_GO: begin
                rd_go      = 1'b1;
                state_next = RD_STREAM;
            end
            RD_STREAM: begin
                pop = avm.read_user_data_available && (rd_cnt_reg < len_reg);
                if ((rd_cnt_reg == len_reg) || (pop && rd_cnt_inc == len_reg))
                    state_next = RD_WAIT;
            end
            RD_WAIT: begin
                if (avm.read_control_done) state_next = FINISH;
            end
            FINISH: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mode_reg             <= '0;
            base_reg             <= '0;
            len_reg              <= '0;
            seed_reg             <= '0;
            wr_cnt_reg           <= '0;
            rd_cnt_reg           <= '0;
            error_count_reg      <= '0;
            first_error_addr_reg <= '0;
            last_read_data_reg   <= '0;
            busy_reg             <= 1'b0;
            done_reg             <= 1'b0;
        end else begin
            done_reg <= (state_reg == FINISH);
            if (state_reg == FINISH) busy_reg <= 1'b0;
            if (accept) begin
                mode_reg             <= mode;
                base_reg             <= base_address;
                len_reg              <= len_in;
                seed_reg             <= seed;
                wr_cnt_reg           <= '0;
                rd_cnt_reg           <= '0;
                error_count_reg      <= '0;
                first_error_addr_reg <= '0;
                busy_reg             <= 1'b1;
            end
            if (push) wr_cnt_reg <= wr_cnt_inc;
            if (pop) begin
                rd_cnt_reg         <= rd_cnt_inc;
                last_read_data_reg <= avm.read_user_buffer_output_data;
                if (mismatch) begin
                    // A saturated count never returns to zero, so zero marks "no error seen yet".
                    if (error_count_reg != '1) error_count_reg <= error_count_reg + COUNTW'(1);
                    if (error_count_reg == '0) first_error_addr_reg <= rd_addr;
                end
            end
        end
    end

    assign busy             = busy_reg;
    assign done             = done_reg;
    assign error_count      = error_count_reg;
    assign first_error_addr = first_error_addr_reg;
    assign last_read_data   = last_read_data_reg;

    assign avm.write_control_fixed_location = 1'b0;
    assign avm.write_control_write_base     = base_reg;
    assign avm.write_control_write_length   = byte_length;
    assign avm.write_control_go             = wr_go;
    assign avm.write_user_write_buffer      = push;
    assign avm.write_user_buffer_data       = seed_reg + DATAWIDTH'(wr_cnt_reg);

    assign avm.read_control_fixed_location  = 1'b0;
    assign avm.read_control_read_base       = base_reg;
    assign avm.read_control_read_length     = byte_length;
    assign avm.read_control_go              = rd_go;
    assign avm.read_user_read_buffer        = pop;
endmodule
